retro_cache_line_controller: RTL and testbench

Sequences line refills for the direct-mapped cartridge cache. On a miss it writes back the victim line byte-by-byte from cache BRAM (Storage) to the cached device (Source) when the victim is dirty. It then fills the line from Source into Storage and signals the cache to install the new tag. It sits between the cache tag/valid logic and the two byte-wide memory ports, and owns the line transfer counter.

---
 rtl/retro_cache_line_controller.sv | 214 +++++++++++++++++++++
 tb/tb_retro_cache_line_controller.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/retro_cache_line_controller.sv
// retro_cache_line_controller
// Line refill sequencer for the direct-mapped cartridge cache. A miss can
// first copy a dirty victim line from Storage (cache BRAM) back to Source.
// The line is then filled byte by byte from Source into Storage. Finally the
// tag logic gets a one-cycle install pulse. All bus outputs are registered
// and decoded from the next-state values. This means a waiting request
// stays stable until its completion input arrives.
module retro_cache_line_controller #(
   parameter int  AddressBusWidth = 16,
   parameter int  CacheLineBits   = 7,
   parameter int  CacheIndexBits  = 7,
   localparam int TagLength       = AddressBusWidth - CacheIndexBits - CacheLineBits
) (
   input  logic                                    Clk,
   input  logic                                    ResetN,
   // cache tag/valid side
   input  logic                                    MissValid,
   input  logic [AddressBusWidth-1:0]              MissAddress,
   input  logic                                    VictimDirty,
   input  logic [TagLength-1:0]                    VictimTag,
   output logic                                    MissReady,
   output logic                                    LineInvalidate,
   output logic                                    LineInstall,
   output logic [CacheIndexBits-1:0]               InstallIndex,
   output logic [TagLength-1:0]                    InstallTag,
   // Storage (cache BRAM) byte port
   output logic [CacheIndexBits+CacheLineBits-1:0] StorageAddress,
   output logic                                    StorageAccess,
   output logic                                    StorageWrite,
   output logic [7:0]                              StorageDout,
   input  logic [7:0]                              StorageDin,
   input  logic                                    StorageDataReady,
   // Source (cached device) byte port
   output logic [AddressBusWidth-1:0]              SourceAddress,
   output logic                                    SourceAccess,
   output logic                                    SourceWrite,
   output logic [7:0]                              SourceDout,
   input  logic [7:0]                              SourceDin,
   input  logic                                    SourceReady
);

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_WB_READ    = 3'd1,
      ST_WB_WRITE   = 3'd2,
      ST_FILL_READ  = 3'd3,
      ST_FILL_WRITE = 3'd4,
      ST_INSTALL    = 3'd5
   } state_t;

   localparam int                       StorageAddrBits = CacheIndexBits + CacheLineBits;
   localparam logic [CacheLineBits-1:0] CNT_LAST        = '1;
   localparam logic [CacheLineBits-1:0] CNT_ONE         = CacheLineBits'(1);

   // sequencing state
   state_t                        state_q, state_d;
   logic [CacheLineBits-1:0]      cnt_q, cnt_d;
   logic [7:0]                    byte_buf_q, byte_buf_d;
   logic [CacheIndexBits-1:0]     miss_index_q, miss_index_d;
   logic [TagLength-1:0]          miss_tag_q, miss_tag_d;
   logic [TagLength-1:0]          victim_tag_q, victim_tag_d;

   // registered outputs
   logic                          miss_ready_q, miss_ready_d;
   logic                          line_install_q, line_install_d;
   logic [StorageAddrBits-1:0]    storage_address_q, storage_address_d;
   logic                          storage_access_q, storage_access_d;
   logic                          storage_write_q, storage_write_d;
   logic [7:0]                    storage_dout_q, storage_dout_d;
   logic [AddressBusWidth-1:0]    source_address_q, source_address_d;
   logic                          source_access_q, source_access_d;
   logic                          source_write_q, source_write_d;
   logic [7:0]                    source_dout_q, source_dout_d;
   logic [TagLength-1:0]          source_tag_d;

   // The byte offset of the missing address does not matter: whole lines move.
   logic                          unused_offset_bits;
   assign unused_offset_bits = ^MissAddress[CacheLineBits-1:0];

   // Next-state and output decode. Outputs are derived from the *_d values,
   // so each registered output matches the state it belongs to.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      byte_buf_d   = byte_buf_q;
      miss_index_d = miss_index_q;
      miss_tag_d   = miss_tag_q;
      victim_tag_d = victim_tag_q;

      case (state_q)
         ST_IDLE: begin
            if (MissValid) begin
               miss_index_d = MissAddress[CacheLineBits +: CacheIndexBits];
               miss_tag_d   = MissAddress[AddressBusWidth-1 -: TagLength];
               victim_tag_d = VictimTag;
               cnt_d        = '0;
               state_d      = VictimDirty ? ST_WB_READ : ST_FILL_READ;
            end
         end
         ST_WB_READ: begin
            if (StorageDataReady) begin
               byte_buf_d = StorageDin;
               state_d    = ST_WB_WRITE;
            end
         end
         ST_WB_WRITE: begin
            if (SourceReady) begin
               if (cnt_q == CNT_LAST) begin
                  cnt_d   = '0;
                  state_d = ST_FILL_READ;
               end else begin
                  cnt_d   = cnt_q + CNT_ONE;
                  state_d = ST_WB_READ;
               end
            end
         end
         ST_FILL_READ: begin
            if (SourceReady) begin
               byte_buf_d = SourceDin;
               state_d    = ST_FILL_WRITE;
            end
         end
         ST_FILL_WRITE: begin
            if (StorageDataReady) begin
               if (cnt_q == CNT_LAST) begin
                  state_d = ST_INSTALL;
               end else begin
                  cnt_d   = cnt_q + CNT_ONE;
                  state_d = ST_FILL_READ;
               end
            end
         end
         ST_INSTALL: begin
            cnt_d   = '0;
            state_d = ST_IDLE;
         end
         default: begin
            cnt_d   = '0;
            state_d = ST_IDLE;
         end
      endcase

      // output decode from the upcoming state
      miss_ready_d     = (state_d == ST_IDLE);
      line_install_d   = (state_d == ST_INSTALL);

      storage_access_d = (state_d == ST_WB_READ) || (state_d == ST_FILL_WRITE);
      storage_write_d  = (state_d == ST_FILL_WRITE);
      storage_address_d = storage_access_d ? {miss_index_d, cnt_d} : '0;
      storage_dout_d   = storage_write_d ? byte_buf_d : 8'h00;

      source_access_d  = (state_d == ST_WB_WRITE) || (state_d == ST_FILL_READ);
      source_write_d   = (state_d == ST_WB_WRITE);
      source_tag_d     = source_write_d ? victim_tag_d : miss_tag_d;
      source_address_d = source_access_d ? {source_tag_d, miss_index_d, cnt_d} : '0;
      source_dout_d    = source_write_d ? byte_buf_d : 8'h00;
   end

   // State, datapath latches and output registers; reset returns to IDLE at once.
   always_ff @(posedge Clk or negedge ResetN) begin
      if (!ResetN) begin
         state_q           <= ST_IDLE;
         cnt_q             <= '0;
         byte_buf_q        <= '0;
         miss_index_q      <= '0;
         miss_tag_q        <= '0;
         victim_tag_q      <= '0;
         miss_ready_q      <= 1'b1;
         line_install_q    <= 1'b0;
         storage_address_q <= '0;
         storage_access_q  <= 1'b0;
         storage_write_q   <= 1'b0;
         storage_dout_q    <= '0;
         source_address_q  <= '0;
         source_access_q   <= 1'b0;
         source_write_q    <= 1'b0;
         source_dout_q     <= '0;
      end else begin
         state_q           <= state_d;
         cnt_q             <= cnt_d;
         byte_buf_q        <= byte_buf_d;
         miss_index_q      <= miss_index_d;
         miss_tag_q        <= miss_tag_d;
         victim_tag_q      <= victim_tag_d;
         miss_ready_q      <= miss_ready_d;
         line_install_q    <= line_install_d;
         storage_address_q <= storage_address_d;
         storage_access_q  <= storage_access_d;
         storage_write_q   <= storage_write_d;
         storage_dout_q    <= storage_dout_d;
         source_address_q  <= source_address_d;
         source_access_q   <= source_access_d;
         source_write_q    <= source_write_d;
         source_dout_q     <= source_dout_d;
      end
   end

   assign MissReady      = miss_ready_q;
   assign LineInvalidate = MissValid && miss_ready_q;
   assign LineInstall    = line_install_q;
   assign InstallIndex   = miss_index_q;
   assign InstallTag     = miss_tag_q;

   assign StorageAddress = storage_address_q;
   assign StorageAccess  = storage_access_q;
   assign StorageWrite   = storage_write_q;
   assign StorageDout    = storage_dout_q;

   assign SourceAddress  = source_address_q;
   assign SourceAccess   = source_access_q;
   assign SourceWrite    = source_write_q;
   assign SourceDout     = source_dout_q;

endmodule

// File: tb/tb_retro_cache_line_controller.sv
// tb_retro_cache_line_controller
// Line-level reference model: each accepted miss expands into the list of
// byte operations it must perform, in order, ending with the install pulse.
// A per-cycle checker walks that list against the DUT ports. Randomized
// memory responders supply the data and the wait states.
module tb_retro_cache_line_controller;

   localparam int K_SRD  = 0;   // Storage read
   localparam int K_SWR  = 1;   // Storage write
   localparam int K_XRD  = 2;   // Source read
   localparam int K_XWR  = 3;   // Source write
   localparam int K_INST = 4;   // install pulse

   typedef struct {
      int kind;
      int addr;
      int from;
   } op_t;

   logic        Clk = 1'b0;
   logic        ResetN;
   logic        MissValid;
   logic [15:0] MissAddress;
   logic        VictimDirty;
   logic [1:0]  VictimTag;
   logic        MissReady;
   logic        LineInvalidate;
   logic        LineInstall;
   logic [6:0]  InstallIndex;
   logic [1:0]  InstallTag;
   logic [13:0] StorageAddress;
   logic        StorageAccess;
   logic        StorageWrite;
   logic [7:0]  StorageDout;
   logic [7:0]  StorageDin;
   logic        StorageDataReady;
   logic [15:0] SourceAddress;
   logic        SourceAccess;
   logic        SourceWrite;
   logic [7:0]  SourceDout;
   logic [7:0]  SourceDin;
   logic        SourceReady;

   retro_cache_line_controller dut (
      .Clk              (Clk),
      .ResetN           (ResetN),
      .MissValid        (MissValid),
      .MissAddress      (MissAddress),
      .VictimDirty      (VictimDirty),
      .VictimTag        (VictimTag),
      .MissReady        (MissReady),
      .LineInvalidate   (LineInvalidate),
      .LineInstall      (LineInstall),
      .InstallIndex     (InstallIndex),
      .InstallTag       (InstallTag),
      .StorageAddress   (StorageAddress),
      .StorageAccess    (StorageAccess),
      .StorageWrite     (StorageWrite),
      .StorageDout      (StorageDout),
      .StorageDin       (StorageDin),
      .StorageDataReady (StorageDataReady),
      .SourceAddress    (SourceAddress),
      .SourceAccess     (SourceAccess),
      .SourceWrite      (SourceWrite),
      .SourceDout       (SourceDout),
      .SourceDin        (SourceDin),
      .SourceReady      (SourceReady)
   );

   always #5 Clk = ~Clk;

   // model memories: contents the two devices must hold
   logic [7:0] src_mem  [0:65535];
   logic [7:0] stor_mem [0:16383];

   op_t q[$];
   op_t h;
   bit  idle_m;
   int  mi, mt;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int accepts = 0;
   int installs = 0;
   int invalidates = 0;
   int accept_cyc = 0;
   int install_cyc = 0;
   int last_latency = 0;
   int first_src = -1;
   int first_sto = -1;
   int seen_idx = 0;
   int seen_tag = 0;
   int wait_max = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   // compare process: checks the DUT against the expected op list every cycle
   initial begin
      forever begin
         @(negedge Clk);
         cyc++;
         if (!ResetN) begin
            q.delete();
            chk("rst_miss_ready", MissReady, 1);
            chk("rst_storage_access", StorageAccess, 0);
            chk("rst_source_access", SourceAccess, 0);
            chk("rst_line_install", LineInstall, 0);
            chk("rst_install_index", InstallIndex, 0);
            chk("rst_invalidate", LineInvalidate, MissValid);
         end else begin
            idle_m = (q.size() == 0);
            chk("miss_ready", MissReady, idle_m);
            chk("line_invalidate", LineInvalidate, MissValid && idle_m);
            if (LineInvalidate) invalidates++;
            if (idle_m) begin
               chk("idle_storage_access", StorageAccess, 0);
               chk("idle_source_access", SourceAccess, 0);
               chk("idle_line_install", LineInstall, 0);
               if (MissValid) begin
                  accepts++;
                  accept_cyc = cyc;
                  first_src = -1;
                  first_sto = -1;
                  mi = (int'(MissAddress) >> 7) & 127;
                  mt = (int'(MissAddress) >> 14) & 3;
                  if (VictimDirty) begin
                     for (int i = 0; i < 128; i++) begin
                        q.push_back('{K_SRD, (mi << 7) | i, 0});
                        q.push_back('{K_XWR, (int'(VictimTag) << 14) | (mi << 7) | i, (mi << 7) | i});
                     end
                  end
                  for (int i = 0; i < 128; i++) begin
                     q.push_back('{K_XRD, (mt << 14) | (mi << 7) | i, 0});
                     q.push_back('{K_SWR, (mi << 7) | i, (mt << 14) | (mi << 7) | i});
                  end
                  q.push_back('{K_INST, mi, mt});
               end
            end else begin
               h = q[0];
               if (SourceAccess && first_src < 0) first_src = int'(SourceAddress);
               if (StorageAccess && first_sto < 0) first_sto = int'(StorageAddress);
               case (h.kind)
                  K_SRD, K_SWR: begin
                     chk("storage_access", StorageAccess, 1);
                     chk("storage_write", StorageWrite, (h.kind == K_SWR));
                     chk("storage_address", StorageAddress, h.addr);
                     chk("source_access_idle", SourceAccess, 0);
                     chk("install_early", LineInstall, 0);
                     if (h.kind == K_SWR) chk("storage_dout", StorageDout, src_mem[h.from]);
                     if (StorageAccess && StorageDataReady) begin
                        if (h.kind == K_SWR) stor_mem[h.addr] = src_mem[h.from];
                        void'(q.pop_front());
                     end
                  end
                  K_XRD, K_XWR: begin
                     chk("source_access", SourceAccess, 1);
                     chk("source_write", SourceWrite, (h.kind == K_XWR));
                     chk("source_address", SourceAddress, h.addr);
                     chk("storage_access_idle", StorageAccess, 0);
                     chk("install_early", LineInstall, 0);
                     if (h.kind == K_XWR) chk("source_dout", SourceDout, stor_mem[h.from]);
                     if (SourceAccess && SourceReady) begin
                        if (h.kind == K_XWR) src_mem[h.addr] = stor_mem[h.from];
                        void'(q.pop_front());
                     end
                  end
                  default: begin
                     chk("line_install", LineInstall, 1);
                     chk("install_index", InstallIndex, h.addr);
                     chk("install_tag", InstallTag, h.from);
                     chk("install_storage_access", StorageAccess, 0);
                     chk("install_source_access", SourceAccess, 0);
                     seen_idx = int'(InstallIndex);
                     seen_tag = int'(InstallTag);
                     installs++;
                     install_cyc = cyc;
                     last_latency = cyc - accept_cyc;
                     $display("line %0d: index=0x%02h tag=%0d latency=%0d cycles", installs, h.addr, h.from, last_latency);
                     void'(q.pop_front());
                  end
               endcase
            end
         end
      end
   end

   // memory responders with random wait states; Ready with no Access is noise
   initial begin
      int src_wait;
      int sto_wait;
      src_wait = 0;
      sto_wait = 0;
      SourceReady = 1'b0;
      SourceDin = 8'h00;
      StorageDataReady = 1'b0;
      StorageDin = 8'h00;
      forever begin
         @(posedge Clk);
         #2;
         if (SourceAccess) begin
            if (src_wait > 0) begin
               SourceReady = 1'b0;
               SourceDin = 8'($urandom);
               src_wait--;
            end else begin
               SourceReady = 1'b1;
               SourceDin = SourceWrite ? 8'($urandom) : src_mem[SourceAddress];
               src_wait = int'($urandom_range(0, wait_max));
            end
         end else begin
            SourceReady = (wait_max == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            SourceDin = 8'($urandom);
         end
         if (StorageAccess) begin
            if (sto_wait > 0) begin
               StorageDataReady = 1'b0;
               StorageDin = 8'($urandom);
               sto_wait--;
            end else begin
               StorageDataReady = 1'b1;
               StorageDin = StorageWrite ? 8'($urandom) : stor_mem[StorageAddress];
               sto_wait = int'($urandom_range(0, wait_max));
            end
         end else begin
            StorageDataReady = (wait_max == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            StorageDin = 8'($urandom);
         end
      end
   end

   task automatic start_miss(input logic [15:0] a, input logic d, input logic [1:0] v);
      int n0;
      n0 = accepts;
      MissAddress = a;
      VictimDirty = d;
      VictimTag = v;
      MissValid = 1'b1;
      for (int k = 0; k < 4000 && accepts == n0; k++) begin
         @(posedge Clk);
         #2;
      end
      MissValid = 1'b0;
      chk("miss_accepted", (accepts != n0), 1);
   endtask

   task automatic wait_installs(input int target);
      for (int k = 0; k < 8000 && installs < target; k++) begin
         @(posedge Clk);
         #2;
      end
      chk("install_reached", (installs >= target), 1);
   endtask

   task automatic wait_fill_read(input bit any, input int low);
      bit hit;
      hit = 0;
      for (int k = 0; k < 4000 && !hit; k++) begin
         @(posedge Clk);
         #2;
         hit = SourceAccess && !SourceWrite && (any || int'(SourceAddress[6:0]) == low);
      end
      chk("fill_read_reached", hit, 1);
   endtask

   initial begin
      int n;
      int inv0;
      int n1;
      for (int i = 0; i < 65536; i++) src_mem[i] = 8'($urandom);
      for (int i = 0; i < 16384; i++) stor_mem[i] = 8'($urandom);
      ResetN = 1'b0;
      MissValid = 1'b0;
      MissAddress = 16'h0000;
      VictimDirty = 1'b0;
      VictimTag = 2'd0;
      repeat (3) @(posedge Clk);
      #2;
      ResetN = 1'b1;

      // clean miss, zero wait states: index 0x35, tag 0, line 0x1A80..0x1AFF
      wait_max = 0;
      n = installs;
      start_miss(16'h1A85, 1'b0, 2'd0);
      wait_installs(n + 1);
      chk("clean_latency", last_latency, 257);
      chk("clean_index", seen_idx, 32'h35);
      chk("clean_tag", seen_tag, 0);
      chk("clean_first_source", first_src, 32'h1A80);
      chk("clean_first_storage", first_sto, 32'h1A80);

      // dirty miss, zero wait states: write-back to 0xC100.., fill from 0x0100..
      n = installs;
      start_miss(16'h0100, 1'b1, 2'd3);
      wait_installs(n + 1);
      chk("dirty_latency", last_latency, 513);
      chk("dirty_first_source", first_src, 32'hC100);
      chk("dirty_first_storage", first_sto, 32'h0100);
      chk("dirty_index", seen_idx, 2);

      // same dirty pattern under random wait states
      wait_max = 5;
      n = installs;
      start_miss(16'h4100, 1'b1, 2'd3);
      wait_installs(n + 1);
      chk("waits_one_install", installs - n, 1);

      // MissValid during FILL_READ with a different address is ignored
      wait_max = 3;
      n = installs;
      inv0 = invalidates;
      start_miss(16'h2300, 1'b0, 2'd0);
      wait_fill_read(1'b1, 0);
      MissAddress = 16'h9900;
      MissValid = 1'b1;
      repeat (2) begin
         @(posedge Clk);
         #2;
      end
      MissValid = 1'b0;
      wait_installs(n + 1);
      chk("busy_invalidates", invalidates - inv0, 1);
      chk("busy_index", seen_idx, 32'h46);

      // reset in the middle of a fill (byte 64), then a fresh miss
      wait_max = 2;
      n = installs;
      start_miss(16'h3C00, 1'b0, 2'd0);
      wait_fill_read(1'b0, 64);
      ResetN = 1'b0;
      #1;
      chk("rst_drop_source", SourceAccess, 0);
      chk("rst_drop_storage", StorageAccess, 0);
      chk("rst_drop_ready", MissReady, 1);
      repeat (2) @(posedge Clk);
      #2;
      ResetN = 1'b1;
      chk("rst_no_install", installs - n, 0);
      start_miss(16'h3C00, 1'b1, 2'd2);
      wait_installs(n + 1);
      chk("restart_first_count", first_sto & 127, 0);

      // back-to-back misses with MissValid held high
      wait_max = 0;
      n = installs;
      inv0 = invalidates;
      n1 = accepts;
      MissAddress = 16'h0A00;
      VictimDirty = 1'b0;
      MissValid = 1'b1;
      for (int k = 0; k < 4000 && accepts == n1; k++) begin
         @(posedge Clk);
         #2;
      end
      MissAddress = 16'h5A80;
      VictimDirty = 1'b1;
      VictimTag = 2'd1;
      n1 = accepts;
      for (int k = 0; k < 4000 && accepts == n1; k++) begin
         @(posedge Clk);
         #2;
      end
      MissValid = 1'b0;
      chk("b2b_gap", accept_cyc - install_cyc, 1);
      wait_installs(n + 2);
      chk("b2b_invalidates", invalidates - inv0, 2);

      // randomized misses
      for (int t = 0; t < 4; t++) begin
         wait_max = int'($urandom_range(0, 5));
         n = installs;
         start_miss(16'($urandom), 1'($urandom), 2'($urandom));
         wait_installs(n + 1);
      end

      repeat (3) @(posedge Clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
